// File: rtl/search_feeder.sv
// search_feeder
//
// Job sequencer between the host command interface and one search core.
// A job (S, L) is accepted over a valid/ready handshake, the operands are
// registered onto the core inputs, the core is held in restart for
// KICK_CYCLES cycles, then released and watched for a rising edge of its
// finish level. The core result (or zero on timeout) is returned with the
// job tag over a second valid/ready handshake. One job is in flight at a time.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        asynchronous active-low reset
//   job_valid    host offers a job
//   job_ready    feeder can accept a job (registered)
//   job_S        search state, word 0 in [WORD-1:0]
//   job_L        search limit
//   core_S       registered S driven to the core
//   core_L       registered L driven to the core
//   core_reset   active-high restart of the core (registered)
//   core_finish  core completion level
//   core_outS    core result
//   res_valid    result available (registered, depends on state only)
//   res_ready    host takes the result
//   res_S        captured result, zero on timeout
//   res_tag      tag of the job that produced the result
//   res_timeout  job was aborted by timeout
module search_feeder #(
   parameter int WORD        = 32,
   parameter int NWORDS      = 4,
   parameter int KICK_CYCLES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   job_valid,
   output logic                   job_ready,
   input  logic [WORD*NWORDS-1:0] job_S,
   input  logic [WORD-1:0]        job_L,
   output logic [WORD*NWORDS-1:0] core_S,
   output logic [WORD-1:0]        core_L,
   output logic                   core_reset,
   input  logic                   core_finish,
   input  logic [WORD*NWORDS-1:0] core_outS,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WORD*NWORDS-1:0] res_S,
   output logic [7:0]             res_tag,
   output logic                   res_timeout
);

   localparam int CYC_W  = $clog2(TIMEOUT);
   localparam int KICK_W = $clog2(KICK_CYCLES + 1);

   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TIMEOUT - 1);
   localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KICK = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         job_cnt;
   logic [7:0]         tag;
   logic               finish_q;
   logic [CYC_W-1:0]   cyc_cnt;
   logic [KICK_W-1:0]  kick_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         job_ready   <= 1'b1;
         core_reset  <= 1'b1;
         core_S      <= '0;
         core_L      <= '0;
         res_valid   <= 1'b0;
         res_S       <= '0;
         res_tag     <= '0;
         res_timeout <= 1'b0;
         job_cnt     <= '0;
         tag         <= '0;
         finish_q    <= 1'b0;
         cyc_cnt     <= '0;
         kick_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               job_ready  <= 1'b1;
               core_reset <= 1'b1;
               if (job_valid && job_ready) begin
                  core_S    <= job_S;
                  core_L    <= job_L;
                  tag       <= job_cnt;
                  job_cnt   <= job_cnt + 8'd1;   // wraps 255 -> 0
                  kick_cnt  <= '0;
                  job_ready <= 1'b0;
                  state     <= KICK;
               end
            end

            KICK: begin
               // Clearing finish_q here means a core whose finish level is
               // still high on the first RUN cycle is treated as finishing.
               finish_q <= 1'b0;
               if (kick_cnt == KICK_LAST) begin
                  core_reset <= 1'b0;
                  cyc_cnt    <= '0;
                  state      <= RUN;
               end else begin
                  kick_cnt <= kick_cnt + KICK_W'(1);
               end
            end

            RUN: begin
               finish_q <= core_finish;
               // A finish edge takes priority over an expiring timeout.
               if (core_finish && !finish_q) begin
                  res_S       <= core_outS;
                  res_timeout <= 1'b0;
                  res_tag     <= tag;
                  res_valid   <= 1'b1;
                  core_reset  <= 1'b1;
                  state       <= DONE;
               end else if (cyc_cnt == CYC_LAST) begin
                  res_S       <= '0;
                  res_timeout <= 1'b1;
                  res_tag     <= tag;
                  res_valid   <= 1'b1;
                  core_reset  <= 1'b1;
                  state       <= DONE;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end

            DONE: begin
               // Core stays parked in reset and the result fields are frozen
               // until the host takes them.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  job_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_search_feeder.sv
// tb_search_feeder
//
// Bench for search_feeder with TIMEOUT=16 and KICK_CYCLES=2. A behavioural
// search core answers each job in one of three ways (finish after d RUN
// cycles, never finish, or finish held high across the restart followed by a
// late extra pulse). A reference model derives, from the job and the core
// behaviour chosen for it, when each output must change and to what value.
module tb_search_feeder;

   localparam int WORD   = 32;
   localparam int NWORDS = 4;
   localparam int SW     = WORD * NWORDS;
   localparam int K      = 2;
   localparam int T      = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            job_valid;
   logic            job_ready;
   logic [SW-1:0]   job_S;
   logic [WORD-1:0] job_L;
   logic [SW-1:0]   core_S;
   logic [WORD-1:0] core_L;
   logic            core_reset;
   logic            core_finish;
   logic [SW-1:0]   core_outS;
   logic            res_valid;
   logic            res_ready;
   logic [SW-1:0]   res_S;
   logic [7:0]      res_tag;
   logic            res_timeout;

   always #5 clk = ~clk;

   search_feeder #(
      .WORD(WORD), .NWORDS(NWORDS), .KICK_CYCLES(K), .TIMEOUT(T)
   ) dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_S(job_S), .job_L(job_L),
      .core_S(core_S), .core_L(core_L), .core_reset(core_reset),
      .core_finish(core_finish), .core_outS(core_outS),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_S(res_S), .res_tag(res_tag), .res_timeout(res_timeout)
   );

   // mode 0: finish level after d RUN cycles; 1: never; 2: high through restart
   typedef struct {
      logic [SW-1:0]   s;
      logic [WORD-1:0] l;
      int              mode;
      int              d;
   } job_t;

   job_t            stim_q[$];
   job_t            cur;
   int              checks = 0;
   int              errors = 0;
   bit              busy = 0;
   int              acc_edge = 0;
   int              ncyc = 0;
   int              tag_cnt = 0;
   int              cur_tag = 0;
   logic [SW-1:0]   last_S = '0;
   logic [WORD-1:0] last_L = '0;
   int              rv_cnt = 0;
   int              hold = 0;
   bit              rand_hold = 0;
   int              run_cnt = 0;

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_lat(input job_t j);
      if (j.mode == 2) return 1;
      if (j.mode == 0 && j.d <= T) return j.d;
      return T;
   endfunction

   function automatic bit exp_to(input job_t j);
      return !(j.mode == 2 || (j.mode == 0 && j.d <= T));
   endfunction

   function automatic logic [SW-1:0] rand_wide();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic push_job(input logic [SW-1:0] s, input logic [WORD-1:0] l,
                           input int mode, input int d);
      job_t j;
      j.s = s; j.l = l; j.mode = mode; j.d = d;
      stim_q.push_back(j);
   endtask

   // One clock: note handshakes seen before the edge, update the model,
   // compare outputs, then play the core and the host for the next edge.
   task automatic cycle();
      bit acc, rh, fin, exp_rv;
      int since;
      acc = reset && job_valid && job_ready;
      rh  = reset && res_valid && res_ready;
      @(posedge clk);
      ncyc++;
      @(negedge clk);
      if (reset) begin
         if (rh) begin
            busy   = 0;
            rv_cnt = 0;
         end
         if (acc && stim_q.size() > 0) begin
            cur      = stim_q.pop_front();
            busy     = 1;
            acc_edge = ncyc;
            cur_tag  = tag_cnt;
            tag_cnt  = (tag_cnt + 1) % 256;
            last_S   = cur.s;
            last_L   = cur.l;
         end
         exp_rv = busy && (ncyc >= acc_edge + K + exp_lat(cur));
         check("job_ready", SW'(job_ready), SW'(!busy));
         check("res_valid", SW'(res_valid), SW'(exp_rv));
         check("core_reset", SW'(core_reset),
               SW'(!busy || (ncyc < acc_edge + K) || exp_rv));
         check("core_S", core_S, last_S);
         check("core_L", SW'(core_L), SW'(last_L));
         if (exp_rv) begin
            check("res_S", res_S, exp_to(cur) ? '0 : cur.s + SW'(1));
            check("res_tag", SW'(res_tag), SW'(cur_tag));
            check("res_timeout", SW'(res_timeout), SW'(exp_to(cur)));
         end
         if (res_valid) begin
            if (rv_cnt == 0 && rand_hold) hold = $urandom_range(0, 2);
            rv_cnt++;
         end
      end
      // behavioural core
      if (core_reset) run_cnt = 0;
      else run_cnt++;
      since = ncyc - acc_edge;
      fin = 1'b0;
      if (busy) begin
         case (cur.mode)
            0: fin = !core_reset && (run_cnt >= cur.d);
            2: fin = (since <= K) || (since >= K + 4 && since <= K + 6);
            default: fin = 1'b0;
         endcase
      end
      core_finish = fin;
      if (fin) core_outS = core_S + ((cur.mode == 2 && since >= K + 4) ? SW'(7) : SW'(1));
      else core_outS = rand_wide();
      // host
      job_valid = (stim_q.size() > 0);
      if (stim_q.size() > 0) begin
         job_S = stim_q[0].s;
         job_L = stim_q[0].l;
      end
      res_ready = (rv_cnt >= hold);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((stim_q.size() > 0 || busy) && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_done"}, SW'(stim_q.size() == 0 && !busy), SW'(1));
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      job_valid = 1'b0;
      stim_q.delete();
      #1;
      check("rst_job_ready", SW'(job_ready), SW'(1));
      check("rst_core_reset", SW'(core_reset), SW'(1));
      check("rst_core_S", core_S, '0);
      check("rst_core_L", SW'(core_L), '0);
      check("rst_res_valid", SW'(res_valid), '0);
      check("rst_res_S", res_S, '0);
      check("rst_res_tag", SW'(res_tag), '0);
      check("rst_res_timeout", SW'(res_timeout), '0);
      busy    = 0;
      tag_cnt = 0;
      last_S  = '0;
      last_L  = '0;
      rv_cnt  = 0;
      cycle();
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [SW-1:0] s;
      cur.s = '0; cur.l = '0; cur.mode = 1; cur.d = 0;
      reset       = 1'b0;
      job_valid   = 1'b0;
      job_S       = '0;
      job_L       = '0;
      core_finish = 1'b0;
      core_outS   = '0;
      res_ready   = 1'b1;
      @(negedge clk);
      do_reset();

      // single job, core finishes 10 cycles after release
      push_job(SW'(2), 32'd1, 0, 10);
      drain("single", 100);

      // ten back-to-back jobs, res_ready always high, tags from 0
      do_reset();
      for (int i = 0; i < 10; i++) push_job(SW'(3 + i), 32'd1, 0, 10);
      drain("b2b", 400);

      // timeout, finish exactly at the timeout cycle, one past it, then normal
      push_job(rand_wide(), $urandom(), 1, 0);
      push_job(rand_wide(), $urandom(), 0, T);
      push_job(rand_wide(), $urandom(), 0, T + 1);
      push_job(rand_wide(), $urandom(), 0, 3);
      drain("timeout", 200);

      // finish high across restart, then a second pulse while result waits
      hold = 8;
      push_job(rand_wide(), $urandom(), 2, 0);
      drain("early_finish", 100);

      // backpressure for 20 cycles with a second job waiting
      hold = 20;
      push_job(rand_wide(), $urandom(), 0, 5);
      push_job(rand_wide(), $urandom(), 0, 2);
      drain("backpressure", 200);
      hold = 0;

      // reset in the middle of RUN aborts the job
      push_job(rand_wide(), $urandom(), 1, 0);
      n = 0;
      while (!(busy && ncyc >= acc_edge + K + 5) && n < 50) begin
         cycle();
         n++;
      end
      check("reach_run", SW'(busy && !core_reset), SW'(1));
      do_reset();

      // 257 random jobs to cover tag wrap
      rand_hold = 1;
      for (int i = 0; i < 257; i++) begin
         s = rand_wide();
         if ($urandom_range(0, 9) == 0) push_job(s, $urandom(), 1, 0);
         else if ($urandom_range(0, 9) == 0) push_job(s, $urandom(), 2, 0);
         else push_job(s, $urandom(), 0, $urandom_range(1, 6));
      end
      drain("wrap", 9000);
      check("tag_count", SW'(tag_cnt), SW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
